rpc2_ctrl_cmd_arbiter: RTL
==========================

RPC2_CTRL_CMD_ARBITER -- requirements
Module: rpc2_ctrl_cmd_arbiter

Interface
REQ-001 The block SHALL use one clock, clk, and one reset, rst, which is synchronous and active-high; there is no other clock or reset.
REQ-002 Parameter CMD_WIDTH, default 48, SHALL set the command word width.
REQ-003 Parameter ARB_MODE, default 0, SHALL select arbitration: 0=round-robin, 1=write-priority with starvation limit.
REQ-004 Parameter MAX_WR_STREAK, default 4, SHALL set the maximum number of consecutive write grants while a read is pending (ARB_MODE=1 only); legal range is 1..15.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 arb_en  in  1  when high, new pops are allowed.
REQ-008 wcmd_empty  in  1  registered empty flag of the write-command FIFO.
REQ-009 wcmd_rd_en  out  1  pop strobe to the write-command FIFO.
REQ-010 wcmd_rd_data  in  CMD_WIDTH  write-command FIFO read data, valid the cycle after the pop.
REQ-011 rcmd_empty, rcmd_rd_en, rcmd_rd_data SHALL be the same as REQ-008..010, for the read-command FIFO.
REQ-012 cmd_valid  out  1  command presented downstream.
REQ-013 cmd_ready  in  1  downstream accept.
REQ-014 cmd_data  out  CMD_WIDTH  captured command word.
REQ-015 cmd_is_write  out  1  1=command came from the write FIFO.
REQ-016 busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, FETCH and HOLD, held in registers.
REQ-018 IDLE: if arb_en=1 and at least one FIFO is non-empty, the block SHALL select a source, assert that source's rd_en for exactly this cycle, and go to FETCH; otherwise it SHALL stay in IDLE.
REQ-019 rd_en outputs SHALL be combinational from the registered state, arb_en, the empty flags and the arbitration registers only; both rd_en outputs SHALL never be high in the same cycle.
REQ-020 FETCH: the block SHALL capture the selected rd_data into cmd_data and set cmd_is_write, then go to HOLD; this state lasts one cycle.
REQ-021 HOLD: cmd_valid=1; cmd_data and cmd_is_write SHALL be stable until cmd_ready=1, after which the next state SHALL be IDLE.
REQ-022 Latency SHALL be: pop in cycle N, then cmd_valid=1 from cycle N+2; peak throughput is one command per 3 cycles.
REQ-023 A register last_grant SHALL record the most recent source (0=read, 1=write) and update on every pop.
REQ-024 ARB_MODE=0, only one FIFO non-empty: that FIFO SHALL be granted.
REQ-025 ARB_MODE=0, both FIFOs non-empty: the source opposite last_grant SHALL be granted.
REQ-026 ARB_MODE=1: write SHALL be granted whenever non-empty, unless read is non-empty and wr_streak==MAX_WR_STREAK, in which case read SHALL be granted.
REQ-027 wr_streak (4 bits) SHALL increment on each write grant made while read is non-empty, saturate at MAX_WR_STREAK, and clear on any read grant.
REQ-028 wr_streak SHALL hold on a write grant made while read is empty.
REQ-029 Deasserting arb_en in FETCH or HOLD SHALL NOT abort the command in flight; it only blocks the next pop.
REQ-030 An empty flag rising during FETCH/HOLD SHALL have no effect on the captured command.
REQ-031 cmd_ready asserted outside HOLD SHALL be ignored.

Reset
REQ-032 On rst=1 at a clock edge, the block SHALL set: state=IDLE, cmd_valid=0, cmd_data=0, cmd_is_write=0, last_grant=0, wr_streak=0, busy=0.
REQ-033 While rst=1, wcmd_rd_en and rcmd_rd_en SHALL be 0.
REQ-034 A reset in FETCH or HOLD SHALL discard the popped command; this loss is accepted and not signalled.

Verification
REQ-035 Single read: rcmd_empty falls with rcmd_rd_data=0xA5 (value valid at N+1), arb_en=1, pop at N -> rcmd_rd_en high only in N; cmd_valid=1 at N+2 with cmd_data=0xA5 and cmd_is_write=0; with cmd_ready=1 at N+2, IDLE at N+3.
REQ-036 Round-robin, both FIFOs holding 3 entries, cmd_ready=1 -> grant order W,R,W,R,W,R.
REQ-037 ARB_MODE=1, MAX_WR_STREAK=2, both FIFOs always non-empty -> grant order W,W,R,W,W,R.
REQ-038 Backpressure: cmd_ready=0 for 5 cycles in HOLD -> cmd_data is unchanged, no rd_en pulses, busy=1; one cycle after cmd_ready=1, the state is IDLE.
REQ-039 arb_en dropped in FETCH -> the command still completes; no pop afterwards while arb_en=0, even with non-empty FIFOs.
REQ-040 rst pulsed in HOLD -> next cycle cmd_valid=0, busy=0, wr_streak=0; the next grant under ARB_MODE=0 with both FIFOs non-empty is write.

Source files
------------

// File: rtl/rpc2_ctrl_cmd_arbiter.sv
// Command arbiter between the write- and read-command FIFOs of the RPC2 controller.
// Pops one command at a time, captures it and holds it downstream until accepted.
module rpc2_ctrl_cmd_arbiter #(
  parameter int unsigned CMD_WIDTH     = 48,
  parameter int unsigned ARB_MODE      = 0,
  parameter int unsigned MAX_WR_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en,
  input  logic                 wcmd_empty,
  output logic                 wcmd_rd_en,
  input  logic [CMD_WIDTH-1:0] wcmd_rd_data,
  input  logic                 rcmd_empty,
  output logic                 rcmd_rd_en,
  input  logic [CMD_WIDTH-1:0] rcmd_rd_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [CMD_WIDTH-1:0] cmd_data,
  output logic                 cmd_is_write,
  output logic                 busy
);

  localparam int unsigned STREAK_W = 4;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [STREAK_W-1:0]   wr_streak_q, wr_streak_d;
  logic [CMD_WIDTH-1:0]  cmd_data_q, cmd_data_d;
  logic                  cmd_is_write_q, cmd_is_write_d;

  logic w_req;
  logic r_req;
  logic sel_wr;
  logic pop;

  // Source selection uses only registered arbitration state and the empty flags
  always_comb begin
    w_req  = ~wcmd_empty;
    r_req  = ~rcmd_empty;
    sel_wr = 1'b0;
    if (ARB_MODE == 0) begin
      if (w_req && r_req) begin
        sel_wr = ~last_grant_q;
      end else begin
        sel_wr = w_req;
      end
    end else begin
      sel_wr = w_req && !(r_req && (wr_streak_q == STREAK_MAX));
    end
    pop = !rst && arb_en && (state_q == IDLE) && (w_req || r_req);
  end

  assign wcmd_rd_en = pop & sel_wr;
  assign rcmd_rd_en = pop & ~sel_wr;

  // Next-state and register updates
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    wr_streak_d    = wr_streak_q;
    cmd_data_d     = cmd_data_q;
    cmd_is_write_d = cmd_is_write_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d      = FETCH;
          last_grant_d = sel_wr;
          if (!sel_wr) begin
            wr_streak_d = '0;
          end else if (r_req && (wr_streak_q != STREAK_MAX)) begin
            wr_streak_d = wr_streak_q + STREAK_W'(1);
          end
        end
      end
      FETCH: begin
        // last_grant was written by the pop one cycle earlier, so it names the source
        cmd_data_d     = last_grant_q ? wcmd_rd_data : rcmd_rd_data;
        cmd_is_write_d = last_grant_q;
        state_d        = HOLD;
      end
      HOLD: begin
        if (cmd_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b0;
      wr_streak_q    <= '0;
      cmd_data_q     <= '0;
      cmd_is_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      wr_streak_q    <= wr_streak_d;
      cmd_data_q     <= cmd_data_d;
      cmd_is_write_q <= cmd_is_write_d;
    end
  end

  assign cmd_valid    = (state_q == HOLD);
  assign busy         = (state_q != IDLE);
  assign cmd_data     = cmd_data_q;
  assign cmd_is_write = cmd_is_write_q;

endmodule
